id_ex_pipe_reg: RTL
===================

Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register for the 5-stage MIPS pipeline. It is the producer side of the EX-stage operand path: it registers the register-file read data, the sign-extended immediate, the register specifiers and the WB/M/EX control bits that the EX-stage operand mux and ALU consume.
- It contains load-use hazard detection. On a hazard it asserts stall to the PC and IF/ID register, and it inserts a one-cycle bubble into EX.
- It supports branch flush and a global hold, and it keeps a saturating bubble counter for performance checks.

Parameters:
CNT_W, 16, width of the saturating load-use bubble counter

Ports:
clk  input  1  pipeline clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
id_read_data1  input  32  ID read data 1 (rs)
id_read_data2  input  32  ID read data 2 (rt)
id_sign_ext  input  32  ID sign-extended immediate
id_rs  input  5  rs specifier
id_rt  input  5  rt specifier
id_rd  input  5  rd specifier
id_wb_ctl  input  2  [1]=RegWrite, [0]=MemtoReg
id_m_ctl  input  3  [2]=Branch, [1]=MemRead, [0]=MemWrite
id_ex_ctl  input  4  [3]=RegDst, [2:1]=ALUOp, [0]=ALUSrc (the EX operand-mux select)
id_valid  input  1  ID holds a real instruction
flush  input  1  discard the instruction currently in ID (taken branch)
hold  input  1  freeze the whole pipeline (downstream multi-cycle op)
ex_read_data1, ex_read_data2, ex_sign_ext  output  32 each  registered copies
ex_rs, ex_rt, ex_rd  output  5 each  registered specifiers
ex_wb_ctl  output  2, ex_m_ctl  output  3, ex_ex_ctl  output  4  registered control
ex_valid  output  1  EX holds a real instruction
stall  output  1  combinational; hold the PC and IF/ID this cycle
bubble_count  output  CNT_W  number of load-use bubbles inserted, saturating

Behaviour:
- Reset, synchronous: all ex_* outputs and bubble_count go to 0. stall goes to 0 during and after reset until the registers hold a hazard.
- Hazard, combinational:
  - haz = ex_valid & ex_m_ctl[1] & (ex_rt != 0) & id_valid & ((ex_rt == id_rs) | (ex_rt == id_rt)).
  - The id_rt compare applies even to instructions that do not read rt. This is deliberately conservative.
- stall = haz & ~flush & ~reset. Hold does not gate stall; the upstream stages already freeze on hold.
- Per-posedge update, highest priority first:
  1. reset: clear everything as above.
  2. hold: every register keeps its value, including ex_valid. bubble_count is unchanged. A flush asserted during hold is ignored; the source keeps flush high until hold drops.
  3. flush: capture a bubble. ex_wb_ctl, ex_m_ctl and ex_ex_ctl go to 0 and ex_valid goes to 0. The data and specifier fields either capture or clear; they are don't-care when ex_valid=0, but the implementation shall clear them to 0 for deterministic waveforms.
  4. haz: capture a bubble as in step 3. bubble_count increments by 1 and saturates at all-ones.
  5. Otherwise capture all id_* inputs; ex_valid <= id_valid.
- id_valid=0 with no other event: the controls are still captured as presented, and ex_valid=0. Downstream qualifies RegWrite, MemWrite and Branch with ex_valid.
- Latency: 1 cycle from ID to EX outputs. A load-use hazard costs exactly 1 bubble. In the cycle after the bubble, ex_m_ctl[1]=0, so haz deasserts and the held instruction then enters EX.
- Back-to-back loads where the second load depends on the first: one bubble, then the second load is captured. Any dependent instruction after it gets its own bubble.
- Every bubble has all control fields zeroed, so it is a true NOP: no register write, no memory access, no branch.

Test Plan:
- Reset: drive reset=1 for 2 cycles while the id_* inputs are non-zero -> all ex_* = 0, bubble_count = 0 and stall = 0 after the first posedge. Deassert reset with id_read_data1=32'h1234_5678 and id_valid=1 -> ex_read_data1 = 32'h1234_5678 and ex_valid=1 one cycle later.
- Plain capture: id_ex_ctl=4'b0001, id_sign_ext=32'hFFFF_FFFC -> ex_ex_ctl[0]=1 and ex_sign_ext=32'hFFFF_FFFC after one posedge, with stall=0 throughout.
- Load-use: EX holds lw with rt=5 (ex_m_ctl=3'b010, ex_valid=1) and ID holds add with rs=5 -> stall=1 that cycle. The next cycle shows ex_valid=0, all ex ctl=0 and bubble_count=1; the cycle after that shows the add in EX and stall=0. Repeat with rt=0 -> no stall.
- Flush vs hazard: load-use condition true and flush=1 in the same cycle -> stall=0, a bubble is captured and bubble_count is unchanged.
- Hold: hold=1 for 3 cycles with changing id_* inputs, a hazard present and flush=1 -> ex_* and bubble_count are frozen at their pre-hold values. After hold drops with flush=0, the hazard bubble is inserted and the count increments.
- Saturation: CNT_W=2; create 5 consecutive load-use hazards -> bubble_count goes 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// -----------------------------------------------------------------------------
// id_ex_pipe_reg
//
// ID/EX pipeline register for a 5-stage MIPS pipeline. It registers the
// register-file read data, sign-extended immediate, register specifiers and
// WB/M/EX control bits that the EX stage consumes. It also detects load-use
// hazards, stalls the front end, and inserts a one-cycle bubble into EX.
//
// Ports:
//   clk, reset                  pipeline clock, synchronous active-high reset
//   id_read_data1/2, id_sign_ext  ID operand data (32 bit)
//   id_rs, id_rt, id_rd         ID register specifiers
//   id_wb_ctl  [1]=RegWrite [0]=MemtoReg
//   id_m_ctl   [2]=Branch [1]=MemRead [0]=MemWrite
//   id_ex_ctl  [3]=RegDst [2:1]=ALUOp [0]=ALUSrc
//   id_valid                    ID holds a real instruction
//   flush                       discard the ID instruction (taken branch)
//   hold                        freeze the whole register
//   ex_*                        registered copies of the above
//   ex_valid                    EX holds a real instruction
//   stall                       combinational; hold PC and IF/ID this cycle
//   bubble_count                saturating count of load-use bubbles
// -----------------------------------------------------------------------------
module id_ex_pipe_reg #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      id_read_data1,
    input  logic [31:0]      id_read_data2,
    input  logic [31:0]      id_sign_ext,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic [1:0]       id_wb_ctl,
    input  logic [2:0]       id_m_ctl,
    input  logic [3:0]       id_ex_ctl,
    input  logic             id_valid,
    input  logic             flush,
    input  logic             hold,
    output logic [31:0]      ex_read_data1,
    output logic [31:0]      ex_read_data2,
    output logic [31:0]      ex_sign_ext,
    output logic [4:0]       ex_rs,
    output logic [4:0]       ex_rt,
    output logic [4:0]       ex_rd,
    output logic [1:0]       ex_wb_ctl,
    output logic [2:0]       ex_m_ctl,
    output logic [3:0]       ex_ex_ctl,
    output logic             ex_valid,
    output logic             stall,
    output logic [CNT_W-1:0] bubble_count
);

    logic [31:0]      r_read_data1;
    logic [31:0]      r_read_data2;
    logic [31:0]      r_sign_ext;
    logic [4:0]       r_rs;
    logic [4:0]       r_rt;
    logic [4:0]       r_rd;
    logic [1:0]       r_wb_ctl;
    logic [2:0]       r_m_ctl;
    logic [3:0]       r_ex_ctl;
    logic             r_valid;
    logic [CNT_W-1:0] r_bubble_count;

    logic w_haz;
    logic w_bubble;
    logic w_count_inc;

    // Load in EX whose destination is read by ID. The rt compare is applied
    // even when ID does not actually read rt; this is deliberately conservative.
    always_comb begin
        w_haz = r_valid & r_m_ctl[1] & (r_rt != 5'd0) & id_valid &
                ((r_rt == id_rs) | (r_rt == id_rt));
    end

    // Flush takes priority over the hazard: the dependent instruction is
    // discarded anyway, so no stall and no count.
    always_comb begin
        stall       = w_haz & ~flush & ~reset;
        w_bubble    = flush | w_haz;
        w_count_inc = w_haz & ~flush & (r_bubble_count != {CNT_W{1'b1}});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_read_data1   <= 32'd0;
            r_read_data2   <= 32'd0;
            r_sign_ext     <= 32'd0;
            r_rs           <= 5'd0;
            r_rt           <= 5'd0;
            r_rd           <= 5'd0;
            r_wb_ctl       <= 2'd0;
            r_m_ctl        <= 3'd0;
            r_ex_ctl       <= 4'd0;
            r_valid        <= 1'b0;
            r_bubble_count <= {CNT_W{1'b0}};
        end else if (!hold) begin
            if (w_bubble) begin
                // Bubble: all fields cleared so EX sees a true NOP and
                // waveforms stay deterministic.
                r_read_data1 <= 32'd0;
                r_read_data2 <= 32'd0;
                r_sign_ext   <= 32'd0;
                r_rs         <= 5'd0;
                r_rt         <= 5'd0;
                r_rd         <= 5'd0;
                r_wb_ctl     <= 2'd0;
                r_m_ctl      <= 3'd0;
                r_ex_ctl     <= 4'd0;
                r_valid      <= 1'b0;
            end else begin
                r_read_data1 <= id_read_data1;
                r_read_data2 <= id_read_data2;
                r_sign_ext   <= id_sign_ext;
                r_rs         <= id_rs;
                r_rt         <= id_rt;
                r_rd         <= id_rd;
                r_wb_ctl     <= id_wb_ctl;
                r_m_ctl      <= id_m_ctl;
                r_ex_ctl     <= id_ex_ctl;
                r_valid      <= id_valid;
            end
            if (w_count_inc) begin
                r_bubble_count <= r_bubble_count + 1'b1;
            end
        end
    end

    assign ex_read_data1 = r_read_data1;
    assign ex_read_data2 = r_read_data2;
    assign ex_sign_ext   = r_sign_ext;
    assign ex_rs         = r_rs;
    assign ex_rt         = r_rt;
    assign ex_rd         = r_rd;
    assign ex_wb_ctl     = r_wb_ctl;
    assign ex_m_ctl      = r_m_ctl;
    assign ex_ex_ctl     = r_ex_ctl;
    assign ex_valid      = r_valid;
    assign bubble_count  = r_bubble_count;

endmodule
